fetch_stage: RTL and testbench

- Instruction fetch front end for the 9-bit core. Sits between the PC/instr_ROM pair and the Control decoder.
- Owns the fetch program counter and drives the instruction ROM address.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode through a valid/ready handshake.
- Flushes on taken jumps, stops at the halt address, and reports done once the queue has drained.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the 9-bit core fetch front end.
package fetch_pkg;

    localparam int D_DEF     = 12;  // program counter width
    localparam int W_DEF     = 9;   // machine code width
    localparam int DEPTH_DEF = 4;   // fetch queue entries

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [D_DEF-1:0] pc;
        logic [W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every register samples pre-edge values.
        if (!reset) begin
            // NOTE: the storage is reset too, so the head fields never show X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, drives the ROM, queues words for decode.
// D and W must match the package defaults because the queue entry is packed
// with those widths.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int D       = D_DEF,
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int HALT_PC = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    output logic [D-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    input  logic         jump_en,
    input  logic [D-1:0] jump_target,
    output logic         dec_valid,
    output logic [W-1:0] dec_instr,
    output logic [D-1:0] dec_pc,
    input  logic         dec_ready,
    output logic         done
);

    localparam logic [D-1:0] HALT_ADDR = D'(HALT_PC);

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [D-1:0]            pc;
    logic [D-1:0]            pc_next;
    logic                    push;
    logic                    pop;
    logic                    flush;
    logic                    q_full;
    logic                    q_empty;
    logic [$clog2(DEPTH):0]  q_count;
    fetch_entry_t            wr_entry;
    fetch_entry_t            head;

    assign rom_addr  = pc;
    assign wr_entry  = '{pc: pc, instr: rom_data};
    assign dec_valid = !q_empty;
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;
    assign pop       = dec_valid && dec_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .head  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Next state, next pc and queue control; a jump beats the halt address.
    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = FETCH;
                    pc_next    = '0;
                end
            end
            FETCH: begin
                if (jump_en) begin
                    flush   = 1'b1;
                    pc_next = jump_target;
                end else if (pc == HALT_ADDR) begin
                    state_next = DRAIN;
                end else begin
                    push = !q_full || pop;
                    if (push) begin
                        pc_next = pc + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (jump_en) begin
                    flush      = 1'b1;
                    pc_next    = jump_target;
                    state_next = FETCH;
                end else if (q_count == '0) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pc and the registered done flag that tracks the HALTED state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            done  <= (state_next == HALTED);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: the bench plays the ROM and keeps a
// scoreboard of the instructions decode must see, in order.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [11:0] rom_addr;
    logic [8:0]  rom_data;
    logic        jump_en;
    logic [11:0] jump_target;
    logic        dec_valid;
    logic [8:0]  dec_instr;
    logic [11:0] dec_pc;
    logic        dec_ready;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    logic [11:0] last_pc = '0;
    fetch_entry_t sb [$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .done        (done)
    );

    function automatic logic [8:0] rom_fn(input logic [11:0] a);
        logic [11:0] t;
        t = a * 12'd37 + 12'd5;
        return t[8:0] ^ {6'b0, a[11:9]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_fill(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            sb.push_back('{pc: 12'(a), instr: rom_fn(12'(a))});
        end
    endtask

    // Scoreboard: every handshake must match the next expected entry.
    always @(negedge clk) begin
        if (dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                check("sb_pc", dec_pc, e.pc);
                check("sb_instr", dec_instr, e.instr);
            end
            last_pc = dec_pc;
            n_pops++;
        end
    end

    initial begin
        reset = 1'b0; req = 1'b0; jump_en = 1'b0; jump_target = '0; dec_ready = 1'b1;

        // Reset and straight-line streaming.
        tick(); tick();
        check("rst_valid", dec_valid, 0);
        check("rst_done", done, 0);
        check("rst_instr", dec_instr, 0);
        check("rst_pc", dec_pc, 0);
        check("rst_addr", rom_addr, 0);
        sb_fill(0, 39);
        reset = 1'b1; req = 1'b1;
        tick();
        check("first_fetch_addr", rom_addr, 0);
        n_pops = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 5) begin
                check("lat_addr", rom_addr, 5);
                check("lat_pc", dec_pc, 4);
            end
        end
        check("throughput", n_pops, 19);

        // Backpressure from the start.
        dec_ready = 1'b0; reset = 1'b0; req = 1'b0;
        tick();
        sb.delete(); sb_fill(0, 39);
        reset = 1'b1; req = 1'b1;
        tick();
        repeat (8) tick();
        check("bp_hold_addr", rom_addr, 4);
        check("bp_valid", dec_valid, 1);
        check("bp_head_pc", dec_pc, 0);
        check("bp_head_instr", dec_instr, rom_fn(12'd0));
        dec_ready = 1'b1;
        repeat (10) tick();

        // Jump flush with pc 5..8 queued.
        dec_ready = 1'b0; reset = 1'b0; req = 1'b0;
        tick();
        sb.delete(); sb_fill(0, 39);
        reset = 1'b1; req = 1'b1; dec_ready = 1'b1;
        tick();
        repeat (6) tick();
        dec_ready = 1'b0;
        repeat (3) tick();
        check("pre_jump_head", dec_pc, 5);
        check("pre_jump_addr", rom_addr, 9);
        sb.delete(); sb_fill(40, 127);
        jump_en = 1'b1; jump_target = 12'd40;
        tick();
        jump_en = 1'b0; dec_ready = 1'b1;
        check("jump_flush_valid", dec_valid, 0);
        check("jump_load_addr", rom_addr, 40);
        tick();
        check("jump_first_valid", dec_valid, 1);
        check("jump_first_pc", dec_pc, 40);

        // Run to the halt address and drain.
        for (int n = 0; n < 200 && !done; n++) tick();
        check("halt_done", done, 1);
        check("halt_last_pc", last_pc, 127);
        check("halt_sb_empty", sb.size(), 0);
        check("halt_addr", rom_addr, 128);
        tick();
        check("halt_done_hold", done, 1);
        req = 1'b0;
        tick();
        check("idle_done_clear", done, 0);
        check("idle_valid", dec_valid, 0);

        // Jump in the same cycle as the halt address.
        sb.delete(); sb_fill(0, 127); sb_fill(10, 60);
        req = 1'b1;
        tick();
        check("restart_addr", rom_addr, 0);
        for (int n = 0; n < 300 && rom_addr != 12'd128; n++) tick();
        check("reach_halt_pc", rom_addr, 128);
        jump_en = 1'b1; jump_target = 12'd10;
        tick();
        jump_en = 1'b0;
        check("resume_addr", rom_addr, 10);
        repeat (5) tick();
        check("resume_done", done, 0);
        check("resume_progress", rom_addr, 15);

        // Jump straight to the halt address.
        dec_ready = 1'b0;
        sb.delete();
        jump_en = 1'b1; jump_target = 12'd128;
        tick();
        jump_en = 1'b0; dec_ready = 1'b1;
        check("jt_halt_flush", dec_valid, 0);
        begin
            int waited = 1;
            while (!done && waited < 3) begin
                tick();
                waited++;
            end
        end
        check("jt_halt_done", done, 1);

        // Reset in the middle of DRAIN with 3 entries queued.
        req = 1'b0;
        tick();
        sb.delete(); sb_fill(0, 127);
        req = 1'b1;
        tick();
        for (int n = 0; n < 300 && rom_addr != 12'd125; n++) tick();
        check("reach_125", rom_addr, 125);
        dec_ready = 1'b0;
        repeat (4) tick();
        check("drain_done_low", done, 0);
        check("drain_head_a", dec_pc, 124);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check("drain_head_b", dec_pc, 125);
        check("drain_still_valid", dec_valid, 1);
        sb.delete();
        reset = 1'b0; req = 1'b0;
        tick();
        check("mid_rst_valid", dec_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", rom_addr, 0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_hold_addr", rom_addr, 0);
        check("idle_hold_valid", dec_valid, 0);
        req = 1'b1;
        tick();
        tick();
        check("idle_resume_addr", rom_addr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
